// File: rtl/zmod_rxdll_seq.sv
// rx MMCM power-up/relock sequencer: drives MMCM reset, retries lock with a
// timeout and bounded budget, qualifies lock before releasing the datapath.
module zmod_rxdll_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             restart,
  input  logic             mmcm_locked,
  output logic             mmcm_rst,
  output logic             dp_rst,
  output logic             ready,
  output logic             fail,
  output logic [7:0]       retry_cnt,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_READY  = 3'd4,
    S_FAIL   = 3'd5
  } st_e;

  localparam int T_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_MAX  = (T_MAX0 > SETTLE_CYCLES) ? T_MAX0 : SETTLE_CYCLES;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock is the first settle cycle,
  // so SETTLE itself only needs SETTLE_CYCLES-1 more locked cycles.
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 2);
  localparam logic [7:0]       RTY_LAST = 8'(MAX_RETRY - 1);

  st_e              cur, nxt;
  logic [TMR_W-1:0] tmr;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             att_fail, retry_clr, lost_inc;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], mmcm_locked};

  assign locked_s = sync_q[1];

  always_comb begin
    nxt       = cur;
    att_fail  = 1'b0;
    retry_clr = 1'b0;
    lost_inc  = 1'b0;
    if (!enable) begin
      nxt = S_IDLE;
    end else if (restart) begin
      nxt       = S_RESET;
      retry_clr = 1'b1;
    end else begin
      case (cur)
        S_IDLE:   nxt = S_RESET;
        S_RESET:  if (tmr == RST_LAST) nxt = S_WAIT;
        S_WAIT: begin
          if (locked_s)             nxt = S_SETTLE;
          else if (tmr == TO_LAST)  att_fail = 1'b1;
        end
        S_SETTLE: begin
          if (!locked_s) att_fail = 1'b1;
          else if (tmr == SET_LAST) begin
            nxt       = S_READY;
            retry_clr = 1'b1;
          end
        end
        S_READY: begin
          if (!locked_s) begin
            nxt      = S_RESET;
            lost_inc = 1'b1;
          end
        end
        S_FAIL:   nxt = S_FAIL;
        default:  nxt = S_IDLE;
      endcase
      if (att_fail) nxt = (retry_cnt == RTY_LAST) ? S_FAIL : S_RESET;
    end
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cur <= S_IDLE;
    else         cur <= nxt;

  // Restart re-enters RESET from RESET, so it must clear the timer explicitly.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn)
      tmr <= '0;
    else if (nxt != cur || restart)
      tmr <= '0;
    else if (cur == S_RESET || cur == S_WAIT || cur == S_SETTLE)
      tmr <= tmr + TMR_W'(1);

  always_ff @(posedge clk or negedge resetn)
    if (!resetn)        retry_cnt <= 8'd0;
    else if (retry_clr) retry_cnt <= 8'd0;
    else if (att_fail)  retry_cnt <= retry_cnt + 8'd1;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn)                       lost_cnt <= '0;
    else if (lost_inc && ~&lost_cnt)   lost_cnt <= lost_cnt + CNT_W'(1);

  always_comb begin
    mmcm_rst = (cur == S_IDLE) || (cur == S_RESET) || (cur == S_FAIL);
    dp_rst   = (cur != S_READY);
    ready    = (cur == S_READY);
    fail     = (cur == S_FAIL);
  end

  assign state = cur;

endmodule
